uart_rx_ctrl: RTL

Receive-side controller that sits beside the 9600-baud UART receiver in the serial front end. It:
- watches the raw RX line and realigns the receiver's bit timer on every start bit;
- supervises each frame with a watchdog;
- queues completed bytes in a small FIFO for the downstream consumer;
- flags overruns, frame stalls and end-of-message idle gaps.

---
 rtl/uart_rx_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive-side controller that sits beside a UART receiver. It realigns the
// receiver's bit timer on every start bit, supervises each frame with a
// watchdog, queues finished bytes in a small FIFO, and reports overruns,
// stalled frames and (optionally) end-of-message idle gaps.
//
// Optional feature macro: UART_RX_CTRL_TIMEOUT_EN
//   defined   -> idle-gap detector drives msg_end
//   undefined -> idle-gap detector is not built, msg_end is tied to 0
//
// Parameters:
//   CLK_DIV     system clocks per bit period
//   FIFO_DEPTH  byte FIFO entries (power of two, 2..64)
//   IDLE_BITS   idle bit periods that mark end of message
//
// Ports:
//   system_clock  in   sole clock
//   reset_n       in   asynchronous active-low reset
//   rx_d_in       in   raw serial line (same net as the receiver input)
//   rx_byte       in   receiver data byte
//   rx_valid      in   receiver data-ready level
//   timer_reset   out  one-cycle pulse resetting the receiver bit timer
//   rd_en         in   consumer pop request
//   rd_data       out  popped byte, held until the next pop
//   rd_valid      out  one-cycle pulse, rd_data valid
//   fifo_empty    out  FIFO holds no bytes
//   fifo_full     out  FIFO holds FIFO_DEPTH bytes
//   fifo_count    out  current occupancy
//   clr_err       in   clears the sticky overrun flag
//   overrun       out  sticky: a byte was dropped on a full FIFO
//   frame_err     out  one-cycle pulse: frame watchdog expired
//   msg_end       out  one-cycle pulse: idle gap after traffic
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int CLK_DIV    = 5208,
    parameter int FIFO_DEPTH = 8,
    parameter int IDLE_BITS  = 20
) (
    input  logic                          system_clock,
    input  logic                          reset_n,
    input  logic                          rx_d_in,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_valid,
    output logic                          timer_reset,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          clr_err,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          msg_end
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WD_MAX = 11 * CLK_DIV;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ALIGN   = 2'd1;
    localparam logic [1:0] ST_RECEIVE = 2'd2;
    localparam logic [1:0] ST_STORE   = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             rxv_q;
    logic [1:0]       state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timer_reset_q;
    logic             frame_err_q, frame_err_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, full_q;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q;
    logic             overrun_q, overrun_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic fall_s;   // synced line went 1 -> 0
    logic rise_s;   // receiver data-ready went 0 -> 1
    logic wr_s;     // byte written at the tail this cycle
    logic drop_s;   // byte dropped on a full FIFO this cycle
    logic pop_s;    // byte popped from the head this cycle

    assign fall_s = rx_prev_q & ~rx_sync_q;
    assign rise_s = rx_valid & ~rxv_q;
    assign pop_s  = rd_en & ~empty_q;
    // A concurrent pop frees the head slot, so a full FIFO can still accept.
    assign wr_s   = (state_q == ST_STORE) & (~full_q | rd_en);
    assign drop_s = (state_q == ST_STORE) & full_q & ~rd_en;

    // Line synchronizer and edge registers; idle line reads as 1 out of reset.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            rxv_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx_d_in;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rxv_q     <= rx_valid;
        end
    end

    // Frame state machine and watchdog next-state logic.
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d = ST_ALIGN;
                    wd_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                // The ALIGN cycle is the first watchdog clock, so the
                // timeout lands 11*CLK_DIV cycles after ALIGN.
                state_d = ST_RECEIVE;
                wd_d    = wd_q + 1'b1;
            end
            ST_RECEIVE: begin
                // A byte arriving on the terminal cycle still wins.
                if (rise_s) begin
                    state_d = ST_STORE;
                end else if (wd_q == WD_LAST) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_STORE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, watchdog and control pulse registers.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            wd_q          <= '0;
            timer_reset_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            timer_reset_q <= (state_d == ST_ALIGN);
            frame_err_q   <= frame_err_d;
        end
    end

    // FIFO pointer, occupancy, read-data and overrun next-state logic.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (wr_s) begin
            tail_d = tail_q + 1'b1;
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d    = head_q + 1'b1;
            rd_data_d = mem_q[head_q];
        end else begin
            head_d    = head_q;
            rd_data_d = rd_data_q;
        end
        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // Set takes priority over a same-cycle clear.
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // FIFO control registers; flags follow the registered count.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CNT_ZERO;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            empty_q    <= (count_d == CNT_ZERO);
            full_q     <= (count_d == CNT_FULL);
            rd_data_q  <= rd_data_d;
            rd_valid_q <= pop_s;
            overrun_q  <= overrun_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge system_clock) begin
        if (wr_s) begin
            mem_q[tail_q] <= rx_byte;
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int IDLE_MAX = IDLE_BITS * CLK_DIV;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
    localparam logic [IDLE_W-1:0] IDLE_TOP  = IDLE_W'(IDLE_MAX);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MAX - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              armed_q, armed_d;
    logic              msg_end_q, msg_end_d;
    logic              line_idle_s;

    assign line_idle_s = (state_q == ST_IDLE) & rx_sync_q;

    // Idle-gap counter saturates so msg_end cannot repeat without new traffic.
    always_comb begin
        idle_d    = idle_q;
        msg_end_d = 1'b0;
        armed_d   = armed_q;
        if (line_idle_s) begin
            if (idle_q != IDLE_TOP) begin
                idle_d = idle_q + 1'b1;
            end else begin
                idle_d = idle_q;
            end
            msg_end_d = armed_q & (idle_q == IDLE_LAST);
        end else begin
            idle_d    = '0;
            msg_end_d = 1'b0;
        end
        if (wr_s) begin
            armed_d = 1'b1;
        end else if (msg_end_d) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    // Idle-gap registers.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_q    <= '0;
            armed_q   <= 1'b0;
            msg_end_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            armed_q   <= armed_d;
            msg_end_q <= msg_end_d;
        end
    end

    assign msg_end = msg_end_q;
`else
    // Idle-gap detection is not built; IDLE_BITS has no effect here.
    localparam logic MSG_END_TIE = 1'b0 & (IDLE_BITS > 0);
    assign msg_end = MSG_END_TIE;
`endif

    assign timer_reset = timer_reset_q;
    assign frame_err   = frame_err_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign fifo_empty  = empty_q;
    assign fifo_full   = full_q;
    assign fifo_count  = count_q;
    assign overrun     = overrun_q;

endmodule
